// File: rtl/frontier_onchip_pkg.sv
// -----------------------------------------------------------------------------
// frontier_onchip_pkg
//
// Shared definitions for the on-chip memory arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths of the
//                             shared RAM (1024 x 32).
//   grant_e                 : encoding of the last-granted port (GNT_A, GNT_B).
//   PORT_A / PORT_B         : bit positions of each port in request/grant vectors.
//   arb_pick()              : pure two-requester grant decision.
// -----------------------------------------------------------------------------
package frontier_onchip_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    // One-hot grant for a 2-entry request vector. A sole requester always
    // wins; on contention FIXED_PRIO favours A, otherwise the port that did
    // not win last time gets the slot.
    function automatic logic [1:0] arb_pick(
        input logic [1:0] req,
        input grant_e     last,
        input bit         fixed_prio
    );
        logic [1:0] gnt;
        gnt = '0;
        if (req[PORT_A] && req[PORT_B]) begin
            if (fixed_prio || (last == GNT_B)) begin
                gnt[PORT_A] = 1'b1;
            end else begin
                gnt[PORT_B] = 1'b1;
            end
        end else begin
            gnt = req;
        end
        return gnt;
    endfunction

endpackage : frontier_onchip_pkg

// File: rtl/frontier_rr_arb2.sv
// -----------------------------------------------------------------------------
// frontier_rr_arb2
//
// Two-requester arbiter with a last-grant register.
//   clk    : system clock
//   reset  : asynchronous active-high reset; forces no grant and sets the
//            last grant to B so that A wins the first contention
//   req    : request vector, bit PORT_A / PORT_B
//   gnt    : one-hot (or zero) grant, combinational from req and last grant
//
// FIXED_PRIO = 0 : round-robin between the two ports
// FIXED_PRIO = 1 : A always wins when it requests
// -----------------------------------------------------------------------------
module frontier_rr_arb2
    import frontier_onchip_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    grant_e last_grant;

    // NOTE: every output of an always_comb gets a default on its first line,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        gnt = '0;
        // Nothing is accepted while reset is held.
        if (!reset) begin
            gnt = arb_pick(req, last_grant, FIXED_PRIO);
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments,
    // so every flop samples values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_B;
        end else if (gnt[PORT_A]) begin
            last_grant <= GNT_A;
        end else if (gnt[PORT_B]) begin
            last_grant <= GNT_B;
        end
    end

endmodule : frontier_rr_arb2

// File: rtl/frontier_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// frontier_onchip_mem_arbiter
//
// Shares one single-port on-chip RAM between two Avalon-MM style masters.
//
// Ports
//   clk, reset               : system clock, asynchronous active-high reset
//   a_* / b_* (inputs)       : address, byteenable, read, write, writedata
//   a_* / b_* (outputs)      : waitrequest, readdata, readdatavalid
//   ram_* (outputs)          : address, byteenable, chipselect, write,
//                              writedata, clken (tied high)
//   ram_readdata (input)     : RAM read data, valid one cycle after address
//
// A port requests when read or write is high; read+write together is treated
// as a write. At most one request is accepted per cycle and an accepted
// request completes in that cycle (waitrequest low). Reads return exactly one
// cycle later, qualified by readdatavalid.
// -----------------------------------------------------------------------------
module frontier_onchip_mem_arbiter
    import frontier_onchip_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,

    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic                b_waitrequest,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       a_rd_accept;
    logic       b_rd_accept;
    logic       a_rd_pend;
    logic       b_rd_pend;

    assign req[PORT_A] = a_read | a_write;
    assign req[PORT_B] = b_read | b_write;

    frontier_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    // Stall every port during reset, otherwise stall only the loser.
    assign a_waitrequest = reset | (req[PORT_A] & ~gnt[PORT_A]);
    assign b_waitrequest = reset | (req[PORT_B] & ~gnt[PORT_B]);

    // RAM-side mux. Port A is the idle default so the address bus does not
    // toggle needlessly when nobody is granted.
    always_comb begin
        ram_address    = a_address;
        ram_byteenable = a_byteenable;
        ram_writedata  = a_writedata;
        ram_write      = 1'b0;
        if (gnt[PORT_B]) begin
            ram_address    = b_address;
            ram_byteenable = b_byteenable;
            ram_writedata  = b_writedata;
            ram_write      = b_write;
        end else if (gnt[PORT_A]) begin
            ram_write      = a_write;
        end
    end

    assign ram_chipselect = |gnt;
    assign ram_clken      = 1'b1;

    // A read is only a read when write is low; read+write is a pure write.
    assign a_rd_accept = gnt[PORT_A] & a_read & ~a_write;
    assign b_rd_accept = gnt[PORT_B] & b_read & ~b_write;

    // Fixed one-cycle read latency: the pending bit lines up with the RAM's
    // registered output. Reset drops any read already in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rd_pend <= 1'b0;
            b_rd_pend <= 1'b0;
        end else begin
            a_rd_pend <= a_rd_accept;
            b_rd_pend <= b_rd_accept;
        end
    end

    assign a_readdatavalid = a_rd_pend;
    assign b_readdatavalid = b_rd_pend;

    // Both ports see the RAM output; readdatavalid alone says whose it is.
    assign a_readdata = ram_readdata;
    assign b_readdata = ram_readdata;

endmodule : frontier_onchip_mem_arbiter
